oric_disk_probe: RTL and testbench

//  Disk-image probe stage between user_io's SD-image interface and the FDC in the Oric top level.
//  On each img_mounted rising edge it reads sector 0 and identifies the format (MFM_DISK or EXTENDED CPC DSK).
//  It then publishes geometry plus fdd_ready/fdd_layout to the FDC.

---
 rtl/oric_disk_probe.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_oric_disk_probe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oric_disk_probe.sv
// -----------------------------------------------------------------------------
// oric_disk_probe
//
// Disk-image probe between the SD-image interface and the FDC. Every time a new
// image is mounted it reads sector 0, recognises either an MFM_DISK header or
// an EXTENDED CPC DSK header, and publishes the geometry plus fdd_ready /
// fdd_layout. While a probe is running it owns the SD bus (probe_busy=1) and the
// top level routes sd_lba/sd_rd from here instead of from the FDC.
//
// Ports
//   clk_24          in   system clock, 24 MHz
//   reset           in   synchronous, active-high
//   img_mounted     in   mount level; a rising edge announces a new image
//   img_size[31:0]  in   image size in bytes, 0 = ejected
//   sd_lba[31:0]    out  sector address (always sector 0)
//   sd_rd           out  sector read request
//   sd_ack          in   transfer acknowledge, high for the whole transfer
//   sd_buff_addr    in   byte index of sd_dout within the sector
//   sd_dout         in   sector data byte
//   sd_dout_strobe  in   one-cycle valid strobe for sd_dout
//   probe_busy      out  probe owns the SD bus
//   probe_error     out  last probe failed (signature, geometry or timeout)
//   fdd_ready       out  valid image identified
//   fdd_layout      out  1 = double-sided image
//   img_format[1:0] out  0 none, 1 MFM_DISK, 2 EDSK
//   img_tracks[7:0] out  tracks per side
//   img_sides[1:0]  out  number of sides (1 or 2)
// -----------------------------------------------------------------------------
module oric_disk_probe #(
    parameter int unsigned MAX_TRACKS     = 90,
    parameter int unsigned TIMEOUT_CYCLES = 12000000
) (
    input  logic        clk_24,
    input  logic        reset,
    input  logic        img_mounted,
    input  logic [31:0] img_size,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_dout,
    input  logic        sd_dout_strobe,
    output logic        probe_busy,
    output logic        probe_error,
    output logic        fdd_ready,
    output logic        fdd_layout,
    output logic [1:0]  img_format,
    output logic [7:0]  img_tracks,
    output logic [1:0]  img_sides
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_CHECK,
        ST_READY,
        ST_ERROR
    } state_t;

    localparam logic [63:0] SIG_MFM  = 64'h4D46_4D5F_4449_534B; // "MFM_DISK"
    localparam logic [63:0] SIG_EDSK = 64'h4558_5445_4E44_4544; // "EXTENDED"
    localparam int          HDR_BYTES = 64;

    state_t      state_reg, state_next;
    logic        img_mounted_q;
    logic        sd_rd_reg, sd_rd_next;
    logic [31:0] cnt_reg, cnt_next;
    logic        busy_reg, busy_next;
    logic        error_reg, error_next;
    logic        ready_reg, ready_next;
    logic        layout_reg, layout_next;
    logic [1:0]  format_reg, format_next;
    logic [7:0]  tracks_reg, tracks_next;
    logic [1:0]  sides_reg, sides_next;

    logic [7:0]  hdr_reg [HDR_BYTES];
    logic        hdr_clear;
    logic        hdr_we;

    logic        mnt_rise;
    logic        timeout_hit;
    logic        start_probe;
    logic        clear_results;

    // Header decode
    logic [63:0] sig_word;
    logic [31:0] mfm_sides, mfm_tracks, mfm_geom;
    logic        is_mfm, is_edsk;
    logic [31:0] chk_tracks, chk_sides;
    logic [1:0]  chk_format;
    logic        chk_pass;
    logic        hdr_unused;

    assign mnt_rise    = img_mounted & ~img_mounted_q;
    assign timeout_hit = (cnt_reg == TIMEOUT_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Header buffer: only the first 64 bytes of the sector matter.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < HDR_BYTES; gi++) begin : g_hdr
            always_ff @(posedge clk_24) begin
                if (reset || hdr_clear) begin
                    hdr_reg[gi] <= '0;
                end else if (hdr_we && sd_buff_addr[5:0] == 6'(gi)) begin
                    hdr_reg[gi] <= sd_dout;
                end
            end
        end
        for (gi = 0; gi < 8; gi++) begin : g_sig
            assign sig_word[63 - 8*gi -: 8] = hdr_reg[gi];
        end
    endgenerate

    // Bytes between the MFM fields and the EDSK geometry bytes are captured but
    // not interpreted.
    always_comb begin
        hdr_unused = 1'b0;
        for (int i = 20; i < HDR_BYTES; i++) begin
            if (i != 'h30 && i != 'h31) begin
                hdr_unused = hdr_unused ^ (^hdr_reg[i]);
            end
        end
    end

    assign mfm_sides  = {hdr_reg[11], hdr_reg[10], hdr_reg[9],  hdr_reg[8]};
    assign mfm_tracks = {hdr_reg[15], hdr_reg[14], hdr_reg[13], hdr_reg[12]};
    assign mfm_geom   = {hdr_reg[19], hdr_reg[18], hdr_reg[17], hdr_reg[16]};
    assign is_mfm     = (sig_word == SIG_MFM);
    assign is_edsk    = (sig_word == SIG_EDSK);

    // Full 32-bit range checks so stray upper bytes reject the image instead of
    // being silently truncated into img_tracks/img_sides.
    always_comb begin
        chk_tracks = '0;
        chk_sides  = '0;
        chk_format = 2'd0;
        chk_pass   = 1'b0;
        if (is_mfm) begin
            chk_tracks = mfm_tracks;
            chk_sides  = mfm_sides;
            chk_format = 2'd1;
            chk_pass   = (mfm_geom == 32'd1 || mfm_geom == 32'd2);
        end else if (is_edsk) begin
            chk_tracks = {24'd0, hdr_reg['h30]};
            chk_sides  = {24'd0, hdr_reg['h31]};
            chk_format = 2'd2;
            chk_pass   = 1'b1;
        end
        chk_pass = chk_pass
                 && (chk_sides == 32'd1 || chk_sides == 32'd2)
                 && (chk_tracks >= 32'd1) && (chk_tracks <= 32'(MAX_TRACKS));
    end

    // -------------------------------------------------------------------------
    // State register (also holds the registered outputs)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_24) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            img_mounted_q <= 1'b0;
            sd_rd_reg     <= 1'b0;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            error_reg     <= 1'b0;
            ready_reg     <= 1'b0;
            layout_reg    <= 1'b0;
            format_reg    <= 2'd0;
            tracks_reg    <= 8'd0;
            sides_reg     <= 2'd0;
        end else begin
            state_reg     <= state_next;
            img_mounted_q <= img_mounted;
            sd_rd_reg     <= sd_rd_next;
            cnt_reg       <= cnt_next;
            busy_reg      <= busy_next;
            error_reg     <= error_next;
            ready_reg     <= ready_next;
            layout_reg    <= layout_next;
            format_reg    <= format_next;
            tracks_reg    <= tracks_next;
            sides_reg     <= sides_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. A new mount always wins over a timeout.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_READY, ST_ERROR: begin
                if (mnt_rise) state_next = (img_size == 32'd0) ? ST_IDLE : ST_REQ;
            end
            ST_REQ: begin
                if (mnt_rise)                state_next = ST_REQ;
                else if (timeout_hit)        state_next = ST_ERROR;
                else if (sd_rd_reg && sd_ack) state_next = ST_XFER;
            end
            ST_XFER: begin
                if (mnt_rise)         state_next = ST_REQ;
                else if (timeout_hit) state_next = ST_ERROR;
                else if (!sd_ack)     state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (mnt_rise)      state_next = ST_REQ;
                else if (chk_pass) state_next = ST_READY;
                else               state_next = ST_ERROR;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        sd_rd_next    = sd_rd_reg;
        cnt_next      = cnt_reg;
        busy_next     = busy_reg;
        error_next    = error_reg;
        ready_next    = ready_reg;
        layout_next   = layout_reg;
        format_next   = format_reg;
        tracks_next   = tracks_reg;
        sides_next    = sides_reg;
        hdr_clear     = 1'b0;
        hdr_we        = 1'b0;
        start_probe   = 1'b0;
        clear_results = 1'b0;

        case (state_reg)
            ST_IDLE, ST_READY, ST_ERROR: begin
                if (mnt_rise) begin
                    clear_results = 1'b1;
                    start_probe   = (img_size != 32'd0);
                end
            end
            ST_REQ, ST_XFER: begin
                if (mnt_rise) begin
                    clear_results = 1'b1;
                    start_probe   = 1'b1;
                end else if (timeout_hit) begin
                    sd_rd_next = 1'b0;
                    error_next = 1'b1;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                    if (state_reg == ST_REQ) begin
                        // Drop the request once acknowledged; after a restart the
                        // request is re-raised only once the old transfer's ack is gone.
                        if (sd_rd_reg) begin
                            if (sd_ack) sd_rd_next = 1'b0;
                        end else if (!sd_ack) begin
                            sd_rd_next = 1'b1;
                        end
                    end else begin
                        hdr_we = sd_dout_strobe && (sd_buff_addr[8:6] == 3'd0);
                    end
                end
            end
            ST_CHECK: begin
                if (mnt_rise) begin
                    clear_results = 1'b1;
                    start_probe   = 1'b1;
                end else begin
                    busy_next = 1'b0;
                    if (chk_pass) begin
                        ready_next  = 1'b1;
                        layout_next = (chk_sides == 32'd2);
                        format_next = chk_format;
                        tracks_next = chk_tracks[7:0];
                        sides_next  = chk_sides[1:0];
                    end else begin
                        error_next  = 1'b1;
                        format_next = 2'd0;
                    end
                end
            end
            default: ;
        endcase

        if (clear_results) begin
            error_next  = 1'b0;
            ready_next  = 1'b0;
            layout_next = 1'b0;
            format_next = 2'd0;
            tracks_next = 8'd0;
            sides_next  = 2'd0;
        end
        if (start_probe) begin
            busy_next = 1'b1;
            cnt_next  = '0;
            hdr_clear = 1'b1;
            // From a settled state the bus is free; mid-probe the previous
            // transfer may still hold sd_ack, so the request waits for it.
            sd_rd_next = (state_reg == ST_REQ || state_reg == ST_XFER ||
                          state_reg == ST_CHECK) ? ~sd_ack : 1'b1;
        end
    end

    assign sd_lba      = 32'd0;
    assign sd_rd       = sd_rd_reg;
    assign probe_busy  = busy_reg;
    assign probe_error = error_reg;
    assign fdd_ready   = ready_reg;
    assign fdd_layout  = layout_reg;
    assign img_format  = format_reg;
    assign img_tracks  = tracks_reg;
    assign img_sides   = sides_reg;

endmodule

// File: tb/tb_oric_disk_probe.sv
module tb_oric_disk_probe;

    logic        clk_24 = 1'b0;
    logic        reset;
    logic        img_mounted;
    logic [31:0] img_size;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_dout;
    logic        sd_dout_strobe;
    logic        probe_busy;
    logic        probe_error;
    logic        fdd_ready;
    logic        fdd_layout;
    logic [1:0]  img_format;
    logic [7:0]  img_tracks;
    logic [1:0]  img_sides;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] img [512];

    always #5 clk_24 = ~clk_24;

    oric_disk_probe #(
        .MAX_TRACKS    (90),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk_24        (clk_24),
        .reset         (reset),
        .img_mounted   (img_mounted),
        .img_size      (img_size),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_ack        (sd_ack),
        .sd_buff_addr  (sd_buff_addr),
        .sd_dout       (sd_dout),
        .sd_dout_strobe(sd_dout_strobe),
        .probe_busy    (probe_busy),
        .probe_error   (probe_error),
        .fdd_ready     (fdd_ready),
        .fdd_layout    (fdd_layout),
        .img_format    (img_format),
        .img_tracks    (img_tracks),
        .img_sides     (img_sides)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Sector image builders: bytes past the header carry filler that would
    // corrupt the signature if addresses >= 0x40 were not ignored.
    task automatic fill_img;
        for (int i = 0; i < 512; i++) img[i] = 8'((i * 7 + 3) & 8'hFF);
    endtask

    task automatic put_sig(input logic [63:0] sig);
        for (int i = 0; i < 8; i++) img[i] = sig[63 - 8*i -: 8];
    endtask

    task automatic put_le32(input int off, input logic [31:0] v);
        for (int i = 0; i < 4; i++) img[off + i] = v[8*i +: 8];
    endtask

    task automatic build_mfm(input logic [63:0] sig, input logic [31:0] sides,
                             input logic [31:0] tracks, input logic [31:0] geom);
        fill_img();
        put_sig(sig);
        put_le32(8, sides);
        put_le32(12, tracks);
        put_le32(16, geom);
    endtask

    task automatic build_edsk(input logic [7:0] tracks, input logic [7:0] sides);
        fill_img();
        put_sig(64'h4558_5445_4E44_4544);
        img['h30] = tracks;
        img['h31] = sides;
    endtask

    // Rising edge of img_mounted; returns at the negedge after the DUT saw it.
    task automatic mount(input logic [31:0] size);
        img_mounted = 1'b0;
        @(negedge clk_24);
        img_mounted = 1'b1;
        img_size    = size;
        @(negedge clk_24);
    endtask

    task automatic ack_start;
        int k = 0;
        while (sd_rd !== 1'b1 && k < 20) begin
            @(negedge clk_24);
            k++;
        end
        check_val("rd_req", {31'd0, sd_rd}, 32'd1);
        sd_ack = 1'b1;
        @(negedge clk_24);
        check_val("rd_drop", {31'd0, sd_rd}, 32'd0);
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            sd_dout_strobe = 1'b1;
            sd_buff_addr   = 9'(i);
            sd_dout        = img[i];
            @(negedge clk_24);
        end
        sd_dout_strobe = 1'b0;
    endtask

    // Full sector transfer; returns one negedge after sd_ack fell (DUT in CHECK).
    task automatic send_sector;
        ack_start();
        stream(72);
        sd_ack = 1'b0;
        @(negedge clk_24);
    endtask

    task automatic expect_result(input string tag, input logic ready, input logic err,
                                 input logic layout, input logic [1:0] fmt,
                                 input logic [7:0] trk, input logic [1:0] sd);
        check_val({tag, "_ready"},  {31'd0, fdd_ready},   {31'd0, ready});
        check_val({tag, "_error"},  {31'd0, probe_error}, {31'd0, err});
        check_val({tag, "_layout"}, {31'd0, fdd_layout},  {31'd0, layout});
        check_val({tag, "_format"}, {30'd0, img_format},  {30'd0, fmt});
        check_val({tag, "_tracks"}, {24'd0, img_tracks},  {24'd0, trk});
        check_val({tag, "_sides"},  {30'd0, img_sides},   {30'd0, sd});
        check_val({tag, "_busy"},   {31'd0, probe_busy},  32'd0);
    endtask

    // Run a full probe of the current img and check the one-cycle CHECK latency.
    task automatic probe_img(input string tag);
        mount(32'd200000);
        check_val({tag, "_busy_start"}, {31'd0, probe_busy}, 32'd1);
        send_sector();
        check_val({tag, "_latency"}, {31'd0, fdd_ready | probe_error}, 32'd0);
        @(negedge clk_24);
    endtask

    initial begin
        reset          = 1'b1;
        img_mounted    = 1'b0;
        img_size       = 32'd0;
        sd_ack         = 1'b0;
        sd_buff_addr   = 9'd0;
        sd_dout        = 8'd0;
        sd_dout_strobe = 1'b0;
        repeat (3) @(negedge clk_24);

        // Reset state
        check_val("rst_sd_rd", {31'd0, sd_rd}, 32'd0);
        check_val("rst_lba", sd_lba, 32'd0);
        expect_result("rst", 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 2'd0);
        reset = 1'b0;
        @(negedge clk_24);

        // 1: MFM, 2 sides, 42 tracks
        build_mfm(64'h4D46_4D5F_4449_534B, 32'd2, 32'd42, 32'd1);
        probe_img("mfm42");
        expect_result("mfm42", 1'b1, 1'b0, 1'b1, 2'd1, 8'd42, 2'd2);

        // 2: EDSK, 40 tracks, 1 side
        build_edsk(8'd40, 8'd1);
        probe_img("edsk40");
        expect_result("edsk40", 1'b1, 1'b0, 1'b0, 2'd2, 8'd40, 2'd1);

        // 3: bad signature
        build_mfm(64'h4D46_4D5F_4449_5343, 32'd2, 32'd42, 32'd1);
        probe_img("badsig");
        expect_result("badsig", 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 2'd0);

        // 4: no ack at all -> timeout after 100 cycles
        mount(32'd200000);
        check_val("to_rd_start", {31'd0, sd_rd}, 32'd1);
        repeat (99) @(negedge clk_24);
        check_val("to_rd_99", {31'd0, sd_rd}, 32'd1);
        check_val("to_err_99", {31'd0, probe_error}, 32'd0);
        @(negedge clk_24);
        check_val("to_rd_100", {31'd0, sd_rd}, 32'd0);
        check_val("to_err_100", {31'd0, probe_error}, 32'd1);
        check_val("to_busy_100", {31'd0, probe_busy}, 32'd0);

        // 8: track boundaries
        build_mfm(64'h4D46_4D5F_4449_534B, 32'd1, 32'd91, 32'd1);
        probe_img("trk91");
        expect_result("trk91", 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 2'd0);
        build_mfm(64'h4D46_4D5F_4449_534B, 32'd1, 32'd90, 32'd2);
        probe_img("trk90");
        expect_result("trk90", 1'b1, 1'b0, 1'b0, 2'd1, 8'd90, 2'd1);

        // Upper byte of sides set: must not truncate to 2
        build_mfm(64'h4D46_4D5F_4449_534B, 32'h0100_0002, 32'd40, 32'd1);
        probe_img("sidehi");
        expect_result("sidehi", 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 2'd0);

        // EDSK with 3 sides
        build_edsk(8'd40, 8'd3);
        probe_img("edsk3s");
        expect_result("edsk3s", 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 2'd0);

        // 5: second mount while the first transfer is running
        build_edsk(8'd40, 8'd1);
        mount(32'd200000);
        ack_start();
        stream(30);
        img_mounted = 1'b0;
        @(negedge clk_24);
        img_mounted = 1'b1;
        @(negedge clk_24);
        check_val("remnt_rd_low", {31'd0, sd_rd}, 32'd0);
        check_val("remnt_busy", {31'd0, probe_busy}, 32'd1);
        sd_ack = 1'b0;
        @(negedge clk_24);
        check_val("remnt_rd_again", {31'd0, sd_rd}, 32'd1);
        build_mfm(64'h4D46_4D5F_4449_534B, 32'd1, 32'd80, 32'd2);
        send_sector();
        check_val("remnt_latency", {31'd0, fdd_ready}, 32'd0);
        @(negedge clk_24);
        expect_result("remnt", 1'b1, 1'b0, 1'b0, 2'd1, 8'd80, 2'd1);

        // 6: eject
        mount(32'd0);
        expect_result("eject", 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 2'd0);
        check_val("eject_rd", {31'd0, sd_rd}, 32'd0);

        // 7: reset in the middle of a transfer
        build_mfm(64'h4D46_4D5F_4449_534B, 32'd2, 32'd42, 32'd1);
        mount(32'd200000);
        ack_start();
        stream(10);
        check_val("mid_busy", {31'd0, probe_busy}, 32'd1);
        reset       = 1'b1;
        img_mounted = 1'b0;
        @(negedge clk_24);
        expect_result("midrst", 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 2'd0);
        check_val("midrst_rd", {31'd0, sd_rd}, 32'd0);
        reset  = 1'b0;
        sd_ack = 1'b0;
        repeat (3) @(negedge clk_24);
        check_val("postrst_busy", {31'd0, probe_busy}, 32'd0);
        check_val("postrst_rd", {31'd0, sd_rd}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
